// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: bus widths, reset PC and FSM states.
package fetch_sequencer_pkg;

  localparam int INSTR_ADDR_BUS = 32;
  localparam int INSTR_BUS      = 32;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h3000_0000;

  typedef enum logic [1:0] {
    FS_BOOT = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fs_state_e;

endpackage

// File: rtl/fetch_sequencer_queue.sv
// fetch_queue: small synchronous FIFO of {pc, instr} pairs.
// Flush has priority over push and pop; push into a full queue is only
// accepted when a pop frees a slot in the same cycle.
module fetch_queue #(
  parameter int DEPTH   = 2,
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  logic [ADDR_W-1:0]  push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic               pop,
  output logic [ADDR_W-1:0]  head_pc,
  output logic [INSTR_W-1:0] head_instr,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
);

  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               push_en;
  logic               pop_en;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);

  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

  // Entry storage write.
  // NOTE: storage carries no reset; count/pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_en && !flush) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
    end
  end

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  // NOTE: sequential state is always updated with non-blocking assignments.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_en, pop_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC generation, instruction-memory sequencing and a small
// instruction queue feeding decode over valid/ready.
// Optional build macro FETCH_PERF_COUNTER_EN adds saturating perf counters
// perf_fetched and perf_stall.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = 2,
  parameter int          ADDR_W   = INSTR_ADDR_BUS,
  parameter int          INSTR_W  = INSTR_BUS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_req,
  output logic               imem_ce,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               out_ready,
  output logic               halted
`ifdef FETCH_PERF_COUNTER_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
`endif
);

  localparam int CNT_W = $clog2(QDEPTH + 1);

  fs_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] redirect_target;
  logic              fetch_ok;
  logic              pop;
  logic              flush;
  logic              q_full;
  logic              q_empty;
  logic [CNT_W-1:0]  q_count;
  logic              unused_bits;

  assign redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_bits     = ^{redirect_pc[1:0], q_count};

  assign out_valid = !q_empty;
  assign pop       = out_valid && out_ready;
  assign flush     = redirect_valid && (state_q != FS_BOOT);
  assign fetch_ok  = (state_q == FS_RUN) && !redirect_valid && !halt_req
                     && (!q_full || pop);

  assign imem_ce   = fetch_ok;
  assign imem_addr = (state_q == FS_BOOT) ? '0 : pc_q;
  assign halted    = (state_q == FS_HALT) && q_empty;

  // Next-state and next-PC selection; redirect dominates, halt is still honoured.
  // NOTE: every combinational output gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      FS_BOOT: begin
        state_d = FS_RUN;
        if (redirect_valid) begin
          pc_d = redirect_target;
          if (halt_req) state_d = FS_HALT;
        end
      end
      FS_RUN, FS_HALT: begin
        if (redirect_valid) begin
          pc_d    = redirect_target;
          state_d = halt_req ? FS_HALT : FS_RUN;
        end else if (state_q == FS_RUN && halt_req) begin
          state_d = FS_HALT;
        end else if (fetch_ok) begin
          pc_d = pc_q + ADDR_W'(4);
        end
      end
      default: begin
        state_d = FS_BOOT;
      end
    endcase
  end

  // State and PC registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FS_BOOT;
      pc_q    <= ADDR_W'(RESET_PC);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_queue #(
    .DEPTH   (QDEPTH),
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push       (fetch_ok),
    .push_pc    (pc_q),
    .push_instr (imem_instr),
    .pop        (pop),
    .head_pc    (out_pc),
    .head_instr (out_instr),
    .count      (q_count),
    .full       (q_full),
    .empty      (q_empty)
  );

`ifdef FETCH_PERF_COUNTER_EN
  logic stall;
  assign stall = (state_q == FS_RUN) && q_full && !pop;

  // Saturating performance counters; only reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (fetch_ok && perf_fetched != '1) perf_fetched <= perf_fetched + 32'd1;
      if (stall && perf_stall != '1)      perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the instruction memory: generates the PC, drives memory chip-enable and address, and buffers returned instructions in a small queue.
- Presents the queue to decode over a valid/ready handshake.
- Accepts branch/jump redirects, which flush the queue, and a halt request.
- Sits between the combinational-read instruction memory and the decode stage. It replaces the free-running PC incrementer.

Parameters:
- RESET_PC, 32'h3000_0000, first fetch address after reset.
- QDEPTH, 2, instruction queue depth in entries. Legal values: 2 or 4.
- ADDR_W, 32, PC/address width (matches `instr_addr_bus`).
- INSTR_W, 32, instruction width (matches `instr_bus`).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset; asserted when 0.
- redirect_valid  in  1  redirect request from execute.
- redirect_pc  in  ADDR_W  redirect target.
- halt_req  in  1  stop fetching after the current cycle.
- imem_ce  out  1  instruction memory chip enable.
- imem_addr  out  ADDR_W  instruction memory address (byte address, word aligned).
- imem_instr  in  INSTR_W  combinational read data for imem_addr.
- out_valid  out  1  queue head holds a valid instruction.
- out_instr  out  INSTR_W  queue head instruction.
- out_pc  out  ADDR_W  PC of the queue head.
- out_ready  in  1  decode accepts the head this cycle.
- halted  out  1  block is in HALT with an empty queue.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=BOOT, pc=RESET_PC, queue count=0, rd/wr pointers=0.
  - Outputs: imem_ce=0, imem_addr=0, out_valid=0, halted=0.
- States and transitions:
  - BOOT: exactly one cycle with imem_ce=0 after reset release, then RUN.
  - RUN: fetch when fetch_ok; go to HALT on halt_req.
  - HALT: imem_ce=0, no fetch. Return to RUN on redirect_valid only.
- Fetch rule:
  - fetch_ok = (state==RUN) && !redirect_valid && (count<QDEPTH || (out_valid && out_ready)).
  - When fetch_ok: imem_ce=1 and imem_addr=pc, both combinational from the registered pc. At posedge, {pc, imem_instr} is enqueued and pc <= pc+4, with wrap-around modulo 2^ADDR_W.
  - When !fetch_ok: imem_ce=0 and imem_addr holds pc.
- Dequeue: out_valid && out_ready pops the head at posedge. Simultaneous push and pop leaves count unchanged.
- Redirect (highest priority, any state except BOOT):
  - Queue flushed, count=0.
  - pc <= {redirect_pc[ADDR_W-1:2], 2'b00}; misaligned low bits are forced to zero.
  - No enqueue that cycle. out_valid=0 from the next cycle.
  - Fetch from the target begins the cycle after the redirect, so target latency is 2 cycles to out_valid.
- redirect_valid during BOOT: the redirect target overrides RESET_PC and BOOT still lasts one cycle.
- halt_req in RUN: the fetch in that same cycle is suppressed and the state goes to HALT. The queue keeps draining to decode. halted=1 when state==HALT && count==0.
- redirect_valid and halt_req together: the redirect wins, pc is loaded, and the next state is HALT. The halt is honoured and the queue is flushed.
- Latency: the first out_valid is 2 cycles after reset release (BOOT cycle, then fetch cycle), with out_pc=RESET_PC.
- Output stability: out_instr/out_pc must not change while out_valid && !out_ready.
- Reset mid-operation: all state is abandoned immediately and there is no drain.

Optional Feature:
- FETCH_PERF_COUNTER_EN defined:
  - Adds outputs perf_fetched (32-bit count of enqueued instructions) and perf_stall (32-bit count of RUN cycles where fetch was blocked by a full queue).
  - Both counters clear on reset and saturate at all-ones.
  - A redirect does not clear them.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package/define file holds:
  - state encodings FS_BOOT=2'd0, FS_RUN=2'd1, FS_HALT=2'd2;
  - RESET_PC default;
  - the existing `instr_addr_bus`/`instr_bus` widths.
- Natural sub-module: fetch_queue, a synchronous FIFO of {pc, instr} with push, pop, flush, count, full and empty. Flush takes priority over push and pop.

Test Plan:
- Reset release, out_ready=1, mem[i]=i+1 → out_valid first rises 2 cycles after release with out_pc=32'h3000_0000 and out_instr=1. Then one instruction per cycle, pc advancing by 4.
- out_ready=0 for 5 cycles with QDEPTH=2 → exactly 2 entries queued, imem_ce=0 while full. On out_ready=1, a pop and push happen in the same cycle and no instruction is lost or duplicated.
- redirect_valid with redirect_pc=32'h3000_0102 while the queue is full → queue flushed, out_valid=0 next cycle, next out_pc=32'h3000_0100.
- halt_req pulse with 2 entries queued → no further imem_ce; halted=1 after the 2 entries pop. A later redirect to 32'h3000_0040 resumes fetch there.
- pc=32'hFFFF_FFFC fetch → next fetch address is 32'h0000_0000 (wrap-around).
- rst asserted mid-stream with a non-empty queue → out_valid=0 and imem_ce=0 immediately, without waiting for a clock edge.
